// File: rtl/clint_timer.sv
// clint_timer: single-hart CLINT providing msip, mtimecmp and mtime over a valid/ready MMIO port.
// Optional mtime prescaler is built in when MTIME_PRESCALE_EN is defined.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR    = 64'h0200_0000,
  parameter int          PRESCALE_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        ext_irq_in,
  output logic        trint,
  output logic        swint,
  output logic        exint,
  output logic [63:0] mtime_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;
  logic [63:0] mtime, mtimecmp, off;
  logic        msip, accept, sel_msip, sel_cmp, sel_time, hit, wr_time, tick;
  logic [1:0]  sync;
  logic        unused_off;

  if (PRESCALE_DIV < 1 || PRESCALE_DIV > 65535) begin : g_bad_div
    $error("PRESCALE_DIV out of range");
  end

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] st);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  assign off        = req_addr - BASE_ADDR;
  assign unused_off = ^{off[63:16], off[2:0]};
  assign sel_msip   = off[15:3] == 13'h0000;
  assign sel_cmp    = off[15:3] == 13'h0800;
  assign sel_time   = off[15:3] == 13'h17FF;
  assign hit        = sel_msip || sel_cmp || sel_time;
  assign accept     = req_valid && req_ready;
  assign wr_time    = accept && req_write && sel_time;

`ifdef MTIME_PRESCALE_EN
  logic [15:0] presc;
  assign tick = presc == 16'(PRESCALE_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) presc <= '0;
    else       presc <= (wr_time || tick) ? '0 : presc + 16'd1;
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    state_nxt  = state == IDLE ? (accept ? RESP : IDLE) : (resp_ready ? IDLE : RESP);
  end

  // Reads capture pre-update values because rdata samples the registers before this edge's writes land.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      trint      <= 1'b0;
      sync       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      mtime <= wr_time ? merge(mtime, req_wdata, req_strb) : mtime + {63'b0, tick};
      if (accept && req_write && sel_cmp) mtimecmp <= merge(mtimecmp, req_wdata, req_strb);
      if (accept && req_write && sel_msip && req_strb[0]) msip <= req_wdata[0];
      trint <= mtime >= mtimecmp;
      sync  <= {sync[0], ext_irq_in};
      if (accept) begin
        resp_err   <= !hit;
        resp_rdata <= (req_write || !hit) ? '0 : sel_msip ? {63'b0, msip} : sel_cmp ? mtimecmp : mtime;
      end
    end

  assign swint   = msip;
  assign exint   = sync[1];
  assign mtime_o = mtime;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized MMIO and interrupt checks of clint_timer against a time-based reference model.
module tb_clint_timer;
  localparam logic [63:0] BASE = 64'h0200_0000, O_MSIP = 64'h0, O_CMP = 64'h4000, O_TIME = 64'hBFF8;
  logic        clk = 0, reset = 1, req_valid = 0, req_write = 0, resp_ready = 0, ext_irq_in = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [7:0]  req_strb = 0;
  logic        req_ready, resp_valid, resp_err, trint, swint, exint;
  logic [63:0] resp_rdata, mtime_o;
  logic [63:0] cyc;
  int vectors = 0, miscompares = 0;
  // mtime is modelled as last written value plus edges elapsed since that write
  logic [63:0] m_base, m_wr, m_cmp;
  logic        m_msip;

  clint_timer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .ext_irq_in(ext_irq_in),
    .trint(trint), .swint(swint), .exint(exint), .mtime_o(mtime_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [63:0] exp_time(input logic [63:0] n);
    return m_base + (n - m_wr);
  endfunction

  function automatic logic [63:0] bytemerge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] m;
    m = {{8{s[7]}}, {8{s[6]}}, {8{s[5]}}, {8{s[4]}}, {8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_base = 0; m_wr = 0; m_cmp = '1; m_msip = 0;
  endtask

  task automatic xact(input logic [63:0] off, input logic w, input logic [63:0] wd, input logic [7:0] st,
                      input int hold, output logic [63:0] rd, output logic e, output logic [63:0] acc,
                      output logic [63:0] mt);
    @(negedge clk);
    req_valid = 1; req_addr = BASE + off; req_write = w; req_wdata = wd; req_strb = st; resp_ready = (hold == 0);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL req_ready_idle got %b want 1", req_ready); end
    @(posedge clk); #1;
    acc = cyc; mt = mtime_o; req_valid = 0;
    vectors++;
    if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL resp_latency got %b want 1", resp_valid); end
    rd = resp_rdata; e = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== e || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_hold v=%b rdata=%h err=%b rdy=%b want v=1 rdata=%h err=%b rdy=0",
                 resp_valid, resp_rdata, resp_err, req_ready, rd, e);
      end
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_done got %b want 0", resp_valid); end
  endtask

  task automatic access(input string nm, input logic [63:0] off, input logic w, input logic [63:0] wd,
                        input logic [7:0] st, input int hold);
    logic [63:0] rd, acc, mt, er;
    logic e, ee;
    xact(off, w, wd, st, hold, rd, e, acc, mt);
    ee = !(off == O_MSIP || off == O_CMP || off == O_TIME);
    er = (w || ee) ? 64'h0 : off == O_TIME ? exp_time(acc - 1) : off == O_CMP ? m_cmp : {63'b0, m_msip};
    vectors++;
    if (rd !== er || e !== ee) begin
      miscompares++;
      $display("FAIL %s rdata=%h err=%b want rdata=%h err=%b", nm, rd, e, er, ee);
    end
    if (w && !ee) begin
      if (off == O_TIME) begin
        m_base = bytemerge(exp_time(acc - 1), wd, st); m_wr = acc;
        vectors++;
        if (mt !== m_base) begin miscompares++; $display("FAIL %s_write_wins mtime=%h want %h", nm, mt, m_base); end
      end else if (off == O_CMP) m_cmp = bytemerge(m_cmp, wd, st);
      else if (st[0]) m_msip = wd[0];
    end
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (mtime_o !== exp_time(cyc) || trint !== (exp_time(cyc - 1) >= m_cmp) || swint !== m_msip) begin
        miscompares++;
        $display("FAIL watch mtime=%h trint=%b swint=%b want mtime=%h trint=%b swint=%b", mtime_o, trint, swint,
                 exp_time(cyc), exp_time(cyc - 1) >= m_cmp, m_msip);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (mtime_o !== 64'd10 || trint !== 0 || swint !== 0 || exint !== 0 || resp_valid !== 0 ||
        resp_rdata !== 0 || resp_err !== 0 || req_ready !== 1) begin
      miscompares++;
      $display("FAIL reset mtime=%0d trint=%b swint=%b exint=%b rv=%b rd=%h err=%b rdy=%b want 10 0 0 0 0 0 0 1",
               mtime_o, trint, swint, exint, resp_valid, resp_rdata, resp_err, req_ready);
    end
  endtask

  task automatic test_timer_irq();
    logic rose = 0;
    access("cmp_20", O_CMP, 1, 64'd20, 8'hFF, 0);
    for (int i = 0; i < 20; i++) begin
      watch(1);
      rose |= trint;
    end
    vectors++;
    if (rose !== 1'b1) begin miscompares++; $display("FAIL trint_rise got %b want 1", rose); end
    access("cmp_max", O_CMP, 1, '1, 8'hFF, 0);
    vectors++;
    if (trint !== 1'b0) begin miscompares++; $display("FAIL trint_fall got %b want 0", trint); end
    watch(3);
    for (int k = 0; k < 6; k++) begin
      access("cmp_near", O_CMP, 1, exp_time(cyc) + 64'($urandom_range(0, 8)), 8'hFF, 0);
      watch(10);
      access("cmp_part", O_CMP, 1, rnd64(), 8'($urandom), 0);
      access("cmp_rd", O_CMP, 0, 0, 0, 0);
      watch(2);
    end
    access("cmp_restore", O_CMP, 1, '1, 8'hFF, 0);
  endtask

  task automatic test_msip();
    access("msip_set", O_MSIP, 1, 64'd1, 8'h01, 0);
    vectors++;
    if (swint !== 1'b1) begin miscompares++; $display("FAIL swint_set got %b want 1", swint); end
    access("msip_rd1", O_MSIP, 0, 0, 0, 0);
    access("msip_nostrb", O_MSIP, 1, 64'd0, 8'hFE, 0);
    access("msip_clr", O_MSIP, 1, 64'd0, 8'h01, 0);
    vectors++;
    if (swint !== 1'b0) begin miscompares++; $display("FAIL swint_clr got %b want 0", swint); end
    for (int k = 0; k < 6; k++) begin
      access("msip_rnd", O_MSIP, 1, rnd64(), 8'($urandom), 0);
      watch(1);
      access("msip_rd", O_MSIP, 0, 0, 0, $urandom_range(0, 2));
    end
  endtask

  task automatic test_mtime();
    access("mtime_wrap", O_TIME, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    @(posedge clk); #1;
    vectors++;
    if (mtime_o !== 64'd0) begin miscompares++; $display("FAIL mtime_wrap got %h want 0", mtime_o); end
    for (int k = 0; k < 6; k++) begin
      access("mtime_wr", O_TIME, 1, rnd64(), (k < 2) ? 8'hFF : 8'($urandom), 0);
      watch($urandom_range(0, 3));
      access("mtime_rd", O_TIME, 0, 0, 0, 0);
    end
    access("mtime_low", O_TIME, 1, 64'd100, 8'hFF, 0);
  endtask

  task automatic test_error();
    access("err_hold", 64'h100, 0, 0, 0, 3);
    access("err_wr", 64'h100, 1, rnd64(), 8'hFF, 0);
    access("err_8", 64'h8, 1, rnd64(), 8'hFF, 0);
    access("err_4008", 64'h4008, 1, rnd64(), 8'hFF, 1);
    access("err_bff0", 64'hBFF0, 0, 0, 0, 2);
    access("cmp_unchanged", O_CMP, 0, 0, 0, 0);
    access("msip_unchanged", O_MSIP, 0, 0, 0, 0);
    watch(2);
  endtask

  task automatic test_exint();
    @(negedge clk); ext_irq_in = 1;
    @(posedge clk); #1;
    vectors++;
    if (exint !== 1'b0) begin miscompares++; $display("FAIL exint_early got %b want 0", exint); end
    @(posedge clk); #1;
    vectors++;
    if (exint !== 1'b1) begin miscompares++; $display("FAIL exint_rise got %b want 1", exint); end
    @(negedge clk); ext_irq_in = 0;
    @(posedge clk); #1;
    vectors++;
    if (exint !== 1'b1) begin miscompares++; $display("FAIL exint_hold got %b want 1", exint); end
    @(posedge clk); #1;
    vectors++;
    if (exint !== 1'b0) begin miscompares++; $display("FAIL exint_fall got %b want 0", exint); end
  endtask

  task automatic test_reset_mid();
    access("msip_pre", O_MSIP, 1, 64'd1, 8'h01, 0);
    access("cmp_zero", O_CMP, 1, 64'd0, 8'hFF, 0);
    watch(2);
    @(negedge clk);
    req_valid = 1; req_addr = BASE + O_TIME; req_write = 0; req_strb = 0; resp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    vectors++;
    if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_resp got %b want 1", resp_valid); end
    #2 reset = 1;
    #1;
    vectors++;
    if (resp_valid !== 0 || mtime_o !== 0 || trint !== 0 || swint !== 0 || resp_rdata !== 0 || req_ready !== 1) begin
      miscompares++;
      $display("FAIL mid_reset rv=%b mtime=%h trint=%b swint=%b rd=%h rdy=%b want 0 0 0 0 0 1",
               resp_valid, mtime_o, trint, swint, resp_rdata, req_ready);
    end
    model_reset();
    @(negedge clk); reset = 0;
    watch(3);
    access("post_reset_rd", O_TIME, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_msip();
    test_mtime();
    test_error();
    test_exint();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
